writeback_stage: RTL
====================

# writeback_stage

Final pipeline stage of the core: takes retired results from the memory stage, waits for data-memory load responses, aligns and extends load data, and drives the register file write port (write_enable_3 / rd_3 / write_data_3). It provides one result per cycle for non-load instructions. Each load occupies the stage until its response arrives or a timeout fires.

## Interface
- LOAD_TIMEOUT, 15: maximum cycles spent in LOAD_WAIT before the load is abandoned (1..255).
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready.
- reg_write  in  1  instruction writes a destination register.
- result_src  in  2  00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU).
- alu_result  in  32  ALU result; for loads, the byte address.
- pc_plus4  in  32  link value for JAL/JALR.
- rd_in  in  5  destination register index.
- funct3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- dmem_rvalid  in  1  load response valid.
- dmem_rdata  in  32  aligned 32-bit word containing the loaded data.
- write_enable_3  out  1  register file write strobe.
- rd_3  out  5  register file write index.
- write_data_3  out  32  register file write data.
- load_error  out  1  one-cycle pulse: misaligned/illegal load or timeout.

## Operation
- FSM states: IDLE, LOAD_WAIT.
- IDLE: in_ready=1. On transfer:
  - result_src != 01 → next cycle write_enable_3 = reg_write && rd_in!=0, rd_3=rd_in, write_data_3 = pc_plus4 (10) or alu_result (otherwise); stay IDLE.
  - result_src == 01 with legal funct3 and aligned address → latch rd_in, reg_write, funct3, alu_result[1:0]; clear timeout counter; go LOAD_WAIT.
  - Illegal/misaligned load → next cycle load_error=1, write_enable_3=0; stay IDLE. Illegal: funct3 in {011,110,111}. Misaligned: LH/LHU with addr[0]=1; LW with addr[1:0]!=00.
- LOAD_WAIT: in_ready=0; counter increments each cycle.
  - dmem_rvalid=1 → next cycle write_enable_3 = latched reg_write && rd!=0, with aligned data; go IDLE.
  - No response and counter reaches LOAD_TIMEOUT → next cycle load_error=1, no write; go IDLE. A dmem_rvalid arriving in IDLE is ignored.
- Load data alignment: byte = dmem_rdata[8*addr+7 -: 8]; half = dmem_rdata[16*addr[1]+15 -: 16]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Register 0 never written: write_enable_3 forced 0 when rd_3==0 (rd_3/write_data_3 still update).

## Timing
- Reset values: state IDLE, write_enable_3=0, rd_3=0, write_data_3=0, load_error=0, counter=0. in_ready=1 in the cycle after reset deasserts.
- in_ready is combinational from state only. It has no path from in_valid.
- Non-load latency: 1 cycle from transfer to write_enable_3. Back-to-back throughput: 1 per cycle.
- Load latency: response cycle + 1. Earliest case: transfer at T, rvalid at T+1, write at T+2.
- The stage re-enters IDLE in the same cycle as the load writeback or the error pulse. A new transfer is accepted in that cycle.
- write_enable_3 and load_error are single-cycle pulses and are never high together.
- Timeout: dmem_rvalid is sampled on cycles T+1 … T+LOAD_TIMEOUT. If no response, load_error is high at T+LOAD_TIMEOUT+1.
- If dmem_rvalid arrives on the final counted cycle, the response wins over the timeout.
- rst mid-load: the stage returns to IDLE next cycle and drops the pending load; no write and no error.

## Test plan
- ALU back-to-back: transfer rd=5 alu=0x12345678 at T and rd=6 alu=0xA at T+1 → write_enable_3 at T+1 (x5=0x12345678) and T+2 (x6=0xA).
- JAL link: result_src=10, rd=1, pc_plus4=0x104 → write_data_3=0x104; rd=0 variant → write_enable_3 stays 0.
- Load extension with dmem_rdata=0x80FF7F01: LB addr 3 → 0xFFFFFF80; LBU addr 1 → 0x7F; LH addr 2 → 0xFFFF80FF; LHU addr 0 → 0x7F01; LW → 0x80FF7F01. Each has a 3-cycle response delay, and in_ready must be 0 while waiting.
- Misaligned/illegal loads: LW addr 0x2, LH addr 0x1, funct3=011 → load_error pulse 1 cycle after transfer, no write, in_ready stays 1.
- Timeout (LOAD_TIMEOUT=15): load with no rvalid → load_error at T+16, then IDLE. Variant with rvalid at T+15 → write at T+16, no error. A late rvalid in IDLE is ignored.
- Reset during LOAD_WAIT, then rvalid asserted → no write, in_ready=1 after reset, all outputs 0.

Source files
------------

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Final pipeline stage. Retires ALU/link results, waits for load
//               responses, aligns/extends load data, drives the regfile port.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage #(
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        reg_write,
    input  logic [1:0]  result_src,
    input  logic [31:0] alu_result,
    input  logic [31:0] pc_plus4,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  funct3,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        write_enable_3,
    output logic [4:0]  rd_3,
    output logic [31:0] write_data_3,
    output logic        load_error
);

    localparam logic       c_IDLE      = 1'b0;
    localparam logic       c_LOAD_WAIT = 1'b1;
    // Counter reads k-1 on the k-th wait cycle, so the last sampled cycle is at TIMEOUT-1.
    localparam logic [7:0] c_CNT_LAST  = 8'(LOAD_TIMEOUT - 1);

    logic        r_state;
    logic        w_state_next;
    logic [7:0]  r_cnt;
    logic [4:0]  r_ld_rd;
    logic        r_ld_we;
    logic [2:0]  r_ld_f3;
    logic [1:0]  r_ld_addr;
    logic        r_we;
    logic        r_err;
    logic [4:0]  r_rd;
    logic [31:0] r_wd;

    logic        w_xfer;
    logic        w_is_load;
    logic        w_ld_illegal;
    logic        w_ld_misaligned;
    logic        w_ld_start;
    logic        w_we_next;
    logic        w_err_next;
    logic [4:0]  w_rd_next;
    logic [31:0] w_wd_next;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;

    assign in_ready       = (r_state == c_IDLE);
    assign w_xfer         = in_valid && in_ready;
    assign w_is_load      = (result_src == 2'b01);
    assign w_ld_illegal   = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    assign w_ld_misaligned = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                             ((funct3 == 3'b010) && (alu_result[1:0] != 2'b00));

    assign write_enable_3 = r_we;
    assign rd_3           = r_rd;
    assign write_data_3   = r_wd;
    assign load_error     = r_err;

    always_comb begin
        w_byte = dmem_rdata[7:0];
        case (r_ld_addr)
            2'd0: w_byte = dmem_rdata[7:0];
            2'd1: w_byte = dmem_rdata[15:8];
            2'd2: w_byte = dmem_rdata[23:16];
            2'd3: w_byte = dmem_rdata[31:24];
            default: w_byte = dmem_rdata[7:0];
        endcase
        w_half = r_ld_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_ld_f3)
            3'b000:  w_ld_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_ld_data = {24'd0, w_byte};
            3'b101:  w_ld_data = {16'd0, w_half};
            default: w_ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_we_next    = 1'b0;
        w_err_next   = 1'b0;
        w_rd_next    = r_rd;
        w_wd_next    = r_wd;
        w_ld_start   = 1'b0;
        if (r_state == c_IDLE) begin
            if (w_xfer) begin
                if (!w_is_load) begin
                    w_we_next = reg_write && (rd_in != 5'd0);
                    w_rd_next = rd_in;
                    w_wd_next = (result_src == 2'b10) ? pc_plus4 : alu_result;
                end else if (w_ld_illegal || w_ld_misaligned) begin
                    w_err_next = 1'b1;
                end else begin
                    w_ld_start   = 1'b1;
                    w_state_next = c_LOAD_WAIT;
                end
            end
        end else begin
            // A response on the final counted cycle takes priority over the timeout.
            if (dmem_rvalid) begin
                w_we_next    = r_ld_we && (r_ld_rd != 5'd0);
                w_rd_next    = r_ld_rd;
                w_wd_next    = w_ld_data;
                w_state_next = c_IDLE;
            end else if (r_cnt == c_CNT_LAST) begin
                w_err_next   = 1'b1;
                w_state_next = c_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= 8'd0;
            r_ld_rd   <= 5'd0;
            r_ld_we   <= 1'b0;
            r_ld_f3   <= 3'd0;
            r_ld_addr <= 2'd0;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_rd      <= 5'd0;
            r_wd      <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_we    <= w_we_next;
            r_err   <= w_err_next;
            r_rd    <= w_rd_next;
            r_wd    <= w_wd_next;
            if (w_ld_start) begin
                r_cnt     <= 8'd0;
                r_ld_rd   <= rd_in;
                r_ld_we   <= reg_write;
                r_ld_f3   <= funct3;
                r_ld_addr <= alu_result[1:0];
            end else if (r_state == c_LOAD_WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire
